// File: rtl/branch_redirect_ctrl_if.sv
// Branch-redirect handshake bundle: EX-stage resolve inputs, redirect outputs, predictor update.
// Optional perf-counter outputs appear when BR_PERF_CNT_EN is defined.
interface branch_redirect_ctrl_if #(
  parameter int PC_W = 32
);
  logic            ex_valid;
  logic            ex_stall;
  logic [PC_W-1:0] ex_pc;
  logic            ex_taken;
  logic [PC_W-1:0] ex_target;
  logic            ex_is_cond;
  logic            ex_pred_taken;
  logic [PC_W-1:0] ex_pred_target;
  logic            ex_hold;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            flush;
  logic            upd_valid;
  logic            upd_ready;
  logic [PC_W-1:0] upd_pc;
  logic [PC_W-1:0] upd_target;
  logic            upd_taken;
  logic            upd_is_cond;
`ifdef BR_PERF_CNT_EN
  logic [31:0]     perf_br_cnt;
  logic [31:0]     perf_mispred_cnt;

  modport master (
    output ex_valid, ex_stall, ex_pc, ex_taken,
    output ex_target, ex_is_cond,
    output ex_pred_taken, ex_pred_target,
    output upd_ready,
    input  ex_hold, redirect_valid, redirect_pc, flush,
    input  upd_valid, upd_pc, upd_target,
    input  upd_taken, upd_is_cond,
    input  perf_br_cnt, perf_mispred_cnt
  );

  modport slave (
    input  ex_valid, ex_stall, ex_pc, ex_taken,
    input  ex_target, ex_is_cond,
    input  ex_pred_taken, ex_pred_target,
    input  upd_ready,
    output ex_hold, redirect_valid, redirect_pc, flush,
    output upd_valid, upd_pc, upd_target,
    output upd_taken, upd_is_cond,
    output perf_br_cnt, perf_mispred_cnt
  );
`else
  modport master (
    output ex_valid, ex_stall, ex_pc, ex_taken,
    output ex_target, ex_is_cond,
    output ex_pred_taken, ex_pred_target,
    output upd_ready,
    input  ex_hold, redirect_valid, redirect_pc, flush,
    input  upd_valid, upd_pc, upd_target,
    input  upd_taken, upd_is_cond
  );

  modport slave (
    input  ex_valid, ex_stall, ex_pc, ex_taken,
    input  ex_target, ex_is_cond,
    input  ex_pred_taken, ex_pred_target,
    input  upd_ready,
    output ex_hold, redirect_valid, redirect_pc, flush,
    output upd_valid, upd_pc, upd_target,
    output upd_taken, upd_is_cond
  );
`endif
endinterface

// File: rtl/branch_redirect_ctrl.sv
// EX branch resolve -> one-cycle redirect/flush plus predictor-update FIFO.
// Define BR_PERF_CNT_EN to add branch / mispredict performance counters.
module branch_redirect_ctrl #(
  parameter int UPD_DEPTH = 4,
  parameter int PC_W      = 32
) (
  input logic               clk,
  input logic               rst,
  branch_redirect_ctrl_if.slave br
);

  localparam int AW = $clog2(UPD_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 * PC_W + 2;

  typedef enum logic {
    S_IDLE,
    S_REDIRECT
  } state_t;

  state_t          r_state;
  logic [PC_W-1:0] r_redir_pc;
  logic [EW-1:0]   r_mem [UPD_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_cnt;
  logic [EW-1:0]   r_head;

  logic            w_idle;
  logic            w_full;
  logic            w_hold;
  logic            w_accept;
  logic            w_mispred;
  logic            w_push;
  logic            w_pop;
  logic [PC_W-1:0] w_correct_pc;
  logic [EW-1:0]   w_wdata;
  logic [EW-1:0]   w_head_nxt;
  logic            w_head_load;
  logic [AW-1:0]   w_rd_nxt;

  assign w_idle    = (r_state == S_IDLE);
  assign w_full    = (r_cnt == CW'(UPD_DEPTH));
  assign w_hold    = br.ex_valid & w_full & w_idle;
  assign w_accept  = br.ex_valid & ~br.ex_stall
                   & ~w_hold & w_idle;
  assign w_mispred = (br.ex_taken != br.ex_pred_taken)
                   | (br.ex_taken
                      & (br.ex_target != br.ex_pred_target));
  assign w_correct_pc = br.ex_taken ? br.ex_target
                                    : br.ex_pc + PC_W'(4);

  assign w_push   = w_accept;
  assign w_pop    = (r_cnt != '0) & br.upd_ready;
  assign w_rd_nxt = r_rd_ptr + AW'(1);
  assign w_wdata  = {br.ex_pc, br.ex_taken,
                     br.ex_target, br.ex_is_cond};

  // Head register tracks the entry that will be at the front next cycle;
  // it is left untouched when the FIFO goes empty so upd_* hold.
  always_comb begin
    w_head_load = 1'b0;
    w_head_nxt  = w_wdata;
    if (w_pop) begin
      if (r_cnt == CW'(1)) begin
        w_head_load = w_push;
      end else begin
        w_head_load = 1'b1;
        w_head_nxt  = r_mem[w_rd_nxt];
      end
    end else if (r_cnt == '0) begin
      w_head_load = w_push;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_redir_pc <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_head     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept && w_mispred) begin
            r_state    <= S_REDIRECT;
            r_redir_pc <= w_correct_pc;
          end
        end
        S_REDIRECT: r_state <= S_IDLE;
        default:    r_state <= S_IDLE;
      endcase
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_nxt;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_head_load) begin
        r_head <= w_head_nxt;
      end
    end
  end

  assign br.ex_hold        = w_hold;
  assign br.redirect_valid = (r_state == S_REDIRECT);
  assign br.flush          = (r_state == S_REDIRECT);
  assign br.redirect_pc    = r_redir_pc;
  assign br.upd_valid      = (r_cnt != '0);
  assign br.upd_pc         = r_head[EW-1 -: PC_W];
  assign br.upd_taken      = r_head[PC_W + 1];
  assign br.upd_target     = r_head[PC_W:1];
  assign br.upd_is_cond    = r_head[0];

`ifdef BR_PERF_CNT_EN
  logic [31:0] r_br_cnt;
  logic [31:0] r_mis_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_br_cnt <= r_br_cnt + 32'd1;
      end
      if (w_accept && w_mispred) begin
        r_mis_cnt <= r_mis_cnt + 32'd1;
      end
    end
  end

  assign br.perf_br_cnt      = r_br_cnt;
  assign br.perf_mispred_cnt = r_mis_cnt;
`endif

endmodule
